ifft4_stream: RTL and testbench
===============================

# ifft4_stream

Streaming 4-point inverse DFT for complex 8-bit (parameterisable) samples. It sits downstream of the team's 4-point forward transform and returns bin-domain data to the time domain. Frequency bins X0..X3 are accepted one per beat on a valid/ready input port and buffered. The transform is computed in one registered cycle. Time samples x0..x3 are emitted one per beat on a valid/ready output port with backpressure.

## Interface
- `W`, default 8: sample width, two's-complement signed, for both the real and imaginary parts.
- `SCALE`, default 1:
  - 1: outputs are divided by 4 using an arithmetic right shift by 2 (floor).
  - 0: no scaling; results wrap modulo 2^W.
- `clk`  in  1  — the single clock; all logic is on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — an input beat is present.
- `in_ready`  out  1  — the block can accept an input beat.
- `in_real`, `in_imag`  in  W each  — bin value X_k.
- `in_last`  in  1  — the source marks this beat as bin 3.
- `out_valid`  out  1  — an output sample is present.
- `out_ready`  in  1  — the sink accepts the output sample.
- `out_real`, `out_imag`  out  W each  — time sample x_n.
- `out_idx`  out  2  — n of the current output sample.
- `out_last`  out  1  — high with x3.
- `frame_err`  out  1  — one-cycle pulse on an in_last framing mismatch.

## Operation
- A transfer occurs on a cycle where valid && ready.
- FSM states: LOAD → CALC → EMIT → LOAD.
- LOAD:
  - in_ready=1; each accepted beat is stored at bin index `cnt` (2-bit), then cnt increments.
  - Accepting the beat at cnt=3 moves the FSM to CALC and resets cnt to 0.
- Framing errors:
  - in_last accepted with cnt<3: frame_err pulses, the partial frame is discarded, cnt=0, the FSM stays in LOAD.
  - cnt=3 accepted without in_last: frame_err pulses, but the frame is processed normally.
- CALC:
  - Lasts one cycle with in_ready=0.
  - Computes the four sums at W+2 bits signed with sign-extended operands, then scales, then registers x0..x3 into the output buffer.
- Transform, with Rk/Ik the real/imaginary parts of Xk:
  - x0 = (R0+R1+R2+R3, I0+I1+I2+I3)
  - x1 = ((R0−R2)+(I1−I3), (I0−I2)−(R1−R3))
  - x2 = ((R0+R2)−(R1+R3), (I0+I2)−(I1+I3))
  - x3 = ((R0−R2)−(I1−I3), (I0−I2)+(R1−R3))
- This is the exact inverse of the forward block's convention, whose bin-1 twiddle is +j.
- Output scaling:
  - SCALE=1: out = sum>>>2; the result always fits W bits.
  - SCALE=0: out = sum[W−1:0].
- EMIT:
  - out_valid=1 and out_idx counts 0..3; each accepted output advances the index.
  - Acceptance with out_idx=3 (out_last=1) returns the FSM to LOAD.
  - While out_ready=0, out_real/out_imag/out_idx/out_last hold stable.
- No overlap between frames: in_ready=0 throughout CALC and EMIT.

## Timing
- Reset values:
  - in_ready=0, out_valid=0, out_real/out_imag=0, out_idx=0, out_last=0, frame_err=0.
  - FSM in LOAD with cnt=0; the input and output buffers are cleared.
- in_ready is registered and rises 1 cycle after rst deasserts.
- Latency: bin 3 accepted on cycle t → CALC on cycle t+1 → out_valid=1 with x0 on cycle t+2.
- Minimum frame period is 10 cycles: 4 load, 1 calc, 4 emit, and 1 for in_ready to re-rise after the last output.
- out_valid falls on the cycle after x3 is accepted.
- All outputs are registered; there is no combinational path from in_* or out_ready to any output.
- frame_err is asserted on the cycle after the offending beat, for exactly 1 cycle.
- rst asserted in any state, including mid-LOAD or mid-EMIT, aborts the frame. On the next edge all reset values apply. No partial output continues after reset.
- in_valid during CALC/EMIT is ignored, because in_ready=0; the source must hold its data.

## Test plan
- SCALE=1, bins (4,0),(0,0),(0,0),(0,0) with in_last on beat 3 → outputs (1,0),(1,0),(1,0),(1,0) with out_idx 0..3 and out_last only on idx 3. First out_valid is 2 cycles after bin 3 is accepted.
- SCALE=1, bins (0,0),(4,0),(0,0),(0,0) → (1,0),(0,−1),(−1,0),(0,1). Feeding these back through the forward block reproduces the inputs scaled by 4.
- SCALE=1, bins (−3,0),(0,0),(0,0),(0,0) → all outputs (−1,0) (floor shift). SCALE=0 with all bins (100,0) → x0=(−112,0) (400 mod 256 = 0x90); x1..x3 = (0,0).
- Backpressure: hold out_ready=0 for 3 cycles while out_idx=2 → out_real/out_imag/out_idx stay constant and in_ready=0. Release → x2 then x3 complete; in_ready returns to 1.
- Framing:
  - in_last on beat 1 → frame_err pulse, no output; the next clean 4-beat frame is transformed correctly.
  - Beat 3 without in_last → frame_err pulse and normal output.
- Reset mid-EMIT after x1 is accepted → the next cycle shows out_valid=0 and all outputs 0. in_ready=1 one cycle after rst falls; a new frame processes correctly.

Source files
------------

// File: rtl/ifft4_stream.sv
// -----------------------------------------------------------------------------
// ifft4_stream
//
// Streaming 4-point inverse DFT for complex signed samples. Four frequency
// bins X0..X3 are collected one per beat, the four time samples are computed
// in a single registered CALC cycle, and x0..x3 are then emitted one per beat
// with backpressure. Frames never overlap: the input port is closed from the
// acceptance of bin 3 until one cycle after x3 has been taken.
//
// The transform uses a -j bin-1 twiddle, undoing the +j convention of the
// matching forward block. SCALE=1 divides by 4 (arithmetic shift, floor);
// SCALE=0 keeps the low W bits of the raw sums.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   input beat present
//   in_ready   block can accept an input beat (registered)
//   in_real    bin real part, W-bit signed
//   in_imag    bin imaginary part, W-bit signed
//   in_last    source marks this beat as bin 3
//   out_valid  output sample present
//   out_ready  sink accepts the output sample
//   out_real   time-sample real part, W-bit signed
//   out_imag   time-sample imaginary part, W-bit signed
//   out_idx    index n of the current time sample
//   out_last   high together with x3
//   frame_err  one-cycle pulse when in_last disagrees with the bin count
// -----------------------------------------------------------------------------
module ifft4_stream #(
   parameter int W     = 8,
   parameter bit SCALE = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_real,
   input  logic signed [W-1:0] in_imag,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] out_real,
   output logic signed [W-1:0] out_imag,
   output logic [1:0]          out_idx,
   output logic                out_last,
   output logic                frame_err
);

   // Four-operand sums of W-bit values need two guard bits.
   localparam int SW = W + 2;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_CALC = 2'd1,
      S_EMIT = 2'd2
   } state_e;

   typedef logic signed [W-1:0]  samp_t;
   typedef logic signed [SW-1:0] wide_t;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   samp_t       ibuf_re_q [4];
   samp_t       ibuf_re_d [4];
   samp_t       ibuf_im_q [4];
   samp_t       ibuf_im_d [4];
   samp_t       obuf_re_q [4];
   samp_t       obuf_re_d [4];
   samp_t       obuf_im_q [4];
   samp_t       obuf_im_d [4];
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   samp_t       out_real_q, out_real_d;
   samp_t       out_imag_q, out_imag_d;
   logic [1:0]  out_idx_q, out_idx_d;
   logic        out_last_q, out_last_d;
   logic        frame_err_q, frame_err_d;

   logic        in_fire;
   logic        out_fire;
   logic [1:0]  nxt_idx;

   wide_t       r [4];
   wide_t       i [4];
   wide_t       sum_re [4];
   wide_t       sum_im [4];
   samp_t       x_re [4];
   samp_t       x_im [4];

   function automatic samp_t scale_f(input wide_t s);
      if (SCALE) return samp_t'(s >>> 2);
      else       return s[W-1:0];
   endfunction

   // ---------------------------------------------------------------------------
   // Butterfly on the buffered bins (sign-extended to SW bits)
   // ---------------------------------------------------------------------------
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         r[k] = wide_t'(ibuf_re_q[k]);
         i[k] = wide_t'(ibuf_im_q[k]);
      end
      sum_re[0] = r[0] + r[1] + r[2] + r[3];
      sum_im[0] = i[0] + i[1] + i[2] + i[3];
      sum_re[1] = (r[0] - r[2]) + (i[1] - i[3]);
      sum_im[1] = (i[0] - i[2]) - (r[1] - r[3]);
      sum_re[2] = (r[0] + r[2]) - (r[1] + r[3]);
      sum_im[2] = (i[0] + i[2]) - (i[1] + i[3]);
      sum_re[3] = (r[0] - r[2]) - (i[1] - i[3]);
      sum_im[3] = (i[0] - i[2]) + (r[1] - r[3]);
      for (int k = 0; k < 4; k++) begin
         x_re[k] = scale_f(sum_re[k]);
         x_im[k] = scale_f(sum_im[k]);
      end
   end

   assign in_fire  = in_valid && in_ready_q;
   assign out_fire = out_valid_q && out_ready;
   assign nxt_idx  = out_idx_q + 2'd1;

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d signal gets its hold value first, so no branch can leave
      // one unassigned and infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      ibuf_re_d   = ibuf_re_q;
      ibuf_im_d   = ibuf_im_q;
      obuf_re_d   = obuf_re_q;
      obuf_im_d   = obuf_im_q;
      in_ready_d  = 1'b0;
      out_valid_d = out_valid_q;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      frame_err_d = 1'b0;

      case (state_q)
         S_LOAD: begin
            // in_ready is registered from the current state, so it is low for
            // one cycle after reset and after the previous frame's x3.
            in_ready_d = 1'b1;
            if (in_fire) begin
               if (in_last && (cnt_q != 2'd3)) begin
                  // Short frame: drop what was collected and restart.
                  frame_err_d = 1'b1;
                  cnt_d       = 2'd0;
               end else begin
                  ibuf_re_d[cnt_q] = in_real;
                  ibuf_im_d[cnt_q] = in_imag;
                  if (cnt_q == 2'd3) begin
                     // Missing in_last is flagged but the frame still runs.
                     frame_err_d = !in_last;
                     cnt_d       = 2'd0;
                     state_d     = S_CALC;
                     in_ready_d  = 1'b0;
                  end else begin
                     cnt_d = cnt_q + 2'd1;
                  end
               end
            end
         end

         S_CALC: begin
            obuf_re_d   = x_re;
            obuf_im_d   = x_im;
            // x0 is presented directly so it appears together with out_valid.
            out_valid_d = 1'b1;
            out_real_d  = x_re[0];
            out_imag_d  = x_im[0];
            out_idx_d   = 2'd0;
            out_last_d  = 1'b0;
            state_d     = S_EMIT;
         end

         S_EMIT: begin
            if (out_fire) begin
               if (out_idx_q == 2'd3) begin
                  out_valid_d = 1'b0;
                  out_real_d  = '0;
                  out_imag_d  = '0;
                  out_idx_d   = 2'd0;
                  out_last_d  = 1'b0;
                  state_d     = S_LOAD;
               end else begin
                  out_real_d  = obuf_re_q[nxt_idx];
                  out_imag_d  = obuf_im_q[nxt_idx];
                  out_idx_d   = nxt_idx;
                  out_last_d  = (nxt_idx == 2'd3);
               end
            end
         end

         default: state_d = S_LOAD;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register here samples the
      // values that existed before this edge regardless of statement order.
      if (rst) begin
         state_q     <= S_LOAD;
         cnt_q       <= 2'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         out_idx_q   <= 2'd0;
         out_last_q  <= 1'b0;
         frame_err_q <= 1'b0;
         // NOTE: the sample buffers are cleared as well; they are only four
         // entries each and a fully defined idle state is part of the contract.
         for (int k = 0; k < 4; k++) begin
            ibuf_re_q[k] <= '0;
            ibuf_im_q[k] <= '0;
            obuf_re_q[k] <= '0;
            obuf_im_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         frame_err_q <= frame_err_d;
         ibuf_re_q   <= ibuf_re_d;
         ibuf_im_q   <= ibuf_im_d;
         obuf_re_q   <= obuf_re_d;
         obuf_im_q   <= obuf_im_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ifft4_stream.sv
// -----------------------------------------------------------------------------
// tb_ifft4_stream
//
// Drives a SCALE=1 and a SCALE=0 instance of ifft4_stream with the same
// stimulus. A behavioural model (direct sum over (-j)^(n*k), frame assembly
// from observed handshakes, and cycle rules for in_ready/out_valid/frame_err)
// is compared against both instances on every falling edge.
// -----------------------------------------------------------------------------
module tb_ifft4_stream;

   localparam int W = 8;

   typedef logic signed [W-1:0] samp_t;
   typedef int arr4_t [4];
   typedef struct {
      int re1;
      int im1;
      int re0;
      int im0;
      int idx;
      bit last;
   } exp_t;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       in_valid  = 1'b0;
   logic       in_last   = 1'b0;
   logic       out_ready = 1'b1;
   samp_t      in_real   = '0;
   samp_t      in_imag   = '0;

   logic       in_ready1, out_valid1, out_last1, frame_err1;
   samp_t      out_real1, out_imag1;
   logic [1:0] out_idx1;
   logic       in_ready0, out_valid0, out_last0, frame_err0;
   samp_t      out_real0, out_imag0;
   logic [1:0] out_idx0;

   int tests = 0;
   int fails = 0;
   int or_mode = 1;   // 1: random out_ready, 0: main thread drives it

   int fr_re [4];
   int fr_im [4];

   always #5 clk = ~clk;

   ifft4_stream #(.W(W), .SCALE(1'b1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready1),
      .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_real(out_real1), .out_imag(out_imag1),
      .out_idx(out_idx1), .out_last(out_last1),
      .frame_err(frame_err1)
   );

   ifft4_stream #(.W(W), .SCALE(1'b0)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready0),
      .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_real(out_real0), .out_imag(out_imag0),
      .out_idx(out_idx0), .out_last(out_last0),
      .frame_err(frame_err0)
   );

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int wrapw(input int v);
      samp_t t;
      t = v[W-1:0];
      return int'(t);
   endfunction

   // x_n = sum_k X_k * (-j)^(n*k), then /4 (floor) or wrap to W bits.
   function automatic void idft(input arr4_t br, input arr4_t bi, input bit scale,
                                output arr4_t xr, output arr4_t xi);
      for (int n = 0; n < 4; n++) begin
         int sr, si;
         sr = 0;
         si = 0;
         for (int k = 0; k < 4; k++) begin
            case ((n * k) % 4)
               0:       begin sr += br[k]; si += bi[k]; end
               1:       begin sr += bi[k]; si -= br[k]; end
               2:       begin sr -= br[k]; si -= bi[k]; end
               default: begin sr -= bi[k]; si += br[k]; end
            endcase
         end
         if (scale) begin
            xr[n] = sr >>> 2;
            xi[n] = si >>> 2;
         end else begin
            xr[n] = wrapw(sr);
            xi[n] = wrapw(si);
         end
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Model state and per-cycle comparison
   // ---------------------------------------------------------------------------
   exp_t pend [$];
   int   mf_re [$];
   int   mf_im [$];
   bit   m_calc = 1'b0;
   bit   m_gap  = 1'b1;
   bit   m_fe   = 1'b0;
   bit   armed  = 1'b0;

   always @(negedge clk) begin
      bit    exp_valid, exp_ready, last_out, n_fe, n_calc;
      arr4_t br, bi, a_r, a_i, b_r, b_i;
      exp_t  e;

      exp_valid = (pend.size() > 0) && !m_calc;
      exp_ready = (pend.size() == 0) && !m_gap;

      if (armed) begin
         check("in_ready",   in_ready1,  exp_ready);
         check("in_ready_s0", in_ready0, exp_ready);
         check("out_valid",  out_valid1, exp_valid);
         check("out_valid_s0", out_valid0, exp_valid);
         check("frame_err",  frame_err1, m_fe);
         check("frame_err_s0", frame_err0, m_fe);
         if (exp_valid) begin
            check("out_real",    out_real1, pend[0].re1);
            check("out_imag",    out_imag1, pend[0].im1);
            check("out_idx",     out_idx1,  pend[0].idx);
            check("out_last",    out_last1, pend[0].last);
            check("out_real_s0", out_real0, pend[0].re0);
            check("out_imag_s0", out_imag0, pend[0].im0);
            check("out_idx_s0",  out_idx0,  pend[0].idx);
            check("out_last_s0", out_last0, pend[0].last);
         end
      end

      // Predict the state after the coming rising edge.
      if (rst) begin
         pend.delete();
         mf_re.delete();
         mf_im.delete();
         m_calc = 1'b0;
         m_gap  = 1'b1;
         m_fe   = 1'b0;
         armed  = 1'b1;
      end else if (armed) begin
         last_out = 1'b0;
         n_fe     = 1'b0;
         n_calc   = 1'b0;
         if (exp_valid && out_ready) begin
            last_out = pend[0].last;
            void'(pend.pop_front());
         end
         if (in_valid && exp_ready) begin
            mf_re.push_back(int'(in_real));
            mf_im.push_back(int'(in_imag));
            if (mf_re.size() == 4) begin
               for (int k = 0; k < 4; k++) begin
                  br[k] = mf_re[k];
                  bi[k] = mf_im[k];
               end
               idft(br, bi, 1'b1, a_r, a_i);
               idft(br, bi, 1'b0, b_r, b_i);
               for (int n = 0; n < 4; n++) begin
                  e.re1  = a_r[n];
                  e.im1  = a_i[n];
                  e.re0  = b_r[n];
                  e.im0  = b_i[n];
                  e.idx  = n;
                  e.last = (n == 3);
                  pend.push_back(e);
               end
               n_fe   = !in_last;
               n_calc = 1'b1;
               mf_re.delete();
               mf_im.delete();
            end else if (in_last) begin
               n_fe = 1'b1;
               mf_re.delete();
               mf_im.delete();
            end
         end
         m_calc = n_calc;
         m_gap  = last_out;
         m_fe   = n_fe;
      end
   end

   // ---------------------------------------------------------------------------
   // Random sink backpressure
   // ---------------------------------------------------------------------------
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (or_mode == 1) out_ready = ($urandom_range(0, 9) < 7);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic set_bins(input int r0, input int i0, input int r1, input int i1,
                           input int r2, input int i2, input int r3, input int i3);
      fr_re[0] = r0; fr_im[0] = i0;
      fr_re[1] = r1; fr_im[1] = i1;
      fr_re[2] = r2; fr_im[2] = i2;
      fr_re[3] = r3; fr_im[3] = i3;
   endtask

   task automatic rand_bins();
      for (int k = 0; k < 4; k++) begin
         fr_re[k] = int'($urandom_range(0, 255)) - 128;
         fr_im[k] = int'($urandom_range(0, 255)) - 128;
      end
   endtask

   // Presents nb beats; last_at is the beat carrying in_last (-1 for none).
   // Returns 1 ns after the edge that accepted the final beat.
   task automatic send_frame(input int nb, input int last_at, input int gapmax);
      for (int b = 0; b < nb; b++) begin
         int g;
         bit ok;
         g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
         in_valid = 1'b0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_real  = samp_t'(fr_re[b]);
         in_imag  = samp_t'(fr_im[b]);
         in_last  = (b == last_at);
         ok = 1'b0;
         for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready1;
            @(posedge clk);
            #1;
         end
         if (!ok) check("in_accept_timeout", ok, 1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle();
      int c;
      c = 0;
      while (!((pend.size() == 0) && (in_ready1 === 1'b1)) && (c < 500)) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (c >= 500) check("idle_timeout", c, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      arr4_t br, bi, pr, pi;
      arr4_t er, ei;
      int    n;

      // Pin the model with hand-computed values.
      br = '{0, 4, 0, 0};
      bi = '{0, 0, 0, 0};
      idft(br, bi, 1'b1, pr, pi);
      er = '{1, 0, -1, 0};
      ei = '{0, -1, 0, 1};
      for (int k = 0; k < 4; k++) begin
         check("pin_bin1_re", pr[k], er[k]);
         check("pin_bin1_im", pi[k], ei[k]);
      end
      br = '{-3, 0, 0, 0};
      idft(br, bi, 1'b1, pr, pi);
      check("pin_floor_x0", pr[0], -1);
      check("pin_floor_x3", pr[3], -1);
      br = '{100, 100, 100, 100};
      idft(br, bi, 1'b0, pr, pi);
      check("pin_wrap_x0", pr[0], -112);
      check("pin_wrap_x1", pr[1], 0);

      // Reset values.
      rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready",  in_ready1,  0);
      check("rst_out_valid", out_valid1, 0);
      check("rst_out_real",  out_real1,  0);
      check("rst_out_imag",  out_imag1,  0);
      check("rst_out_idx",   out_idx1,   0);
      check("rst_out_last",  out_last1,  0);
      check("rst_frame_err", frame_err1, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_low_first_cycle", in_ready1, 0);
      @(negedge clk);
      check("in_ready_rises", in_ready1, 1);
      @(posedge clk);
      #1;

      // Impulse at bin 0, with the bin-3-to-x0 latency measured.
      set_bins(4, 0, 0, 0, 0, 0, 0, 0);
      send_frame(4, 3, 0);
      n = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid1 === 1'b1) break;
         n++;
         @(posedge clk);
         #1;
      end
      check("latency_to_x0", n, 2);
      wait_idle();

      // Bin 1, negative floor case, SCALE=0 wrap, extremes.
      set_bins(0, 0, 4, 0, 0, 0, 0, 0);
      send_frame(4, 3, 0);
      wait_idle();
      set_bins(-3, 0, 0, 0, 0, 0, 0, 0);
      send_frame(4, 3, 1);
      wait_idle();
      set_bins(100, 0, 100, 0, 100, 0, 100, 0);
      send_frame(4, 3, 0);
      wait_idle();
      set_bins(-128, 127, -128, 127, -128, -128, 127, -128);
      send_frame(4, 3, 0);
      wait_idle();

      // Backpressure held at x2 for three cycles.
      or_mode   = 0;
      out_ready = 1'b1;
      rand_bins();
      send_frame(4, 3, 0);
      for (int c = 0; c < 50; c++) begin
         if ((out_valid1 === 1'b1) && (out_idx1 == 2'd2)) break;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_idx_held", out_idx1, 2);
         check("bp_in_ready", in_ready1, 0);
         check("bp_valid", out_valid1, 1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_idle();
      check("bp_in_ready_back", in_ready1, 1);

      // Early in_last on beat 1: error pulse, frame dropped.
      set_bins(7, 7, 9, 9, 0, 0, 0, 0);
      send_frame(2, 1, 0);
      @(negedge clk);
      check("early_last_err", frame_err1, 1);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         check("early_last_no_out", out_valid1, 0);
      end
      @(posedge clk);
      #1;
      set_bins(8, -4, 0, 12, -16, 0, 4, 4);
      send_frame(4, 3, 0);
      wait_idle();

      // Beat 3 without in_last: error pulse, normal output.
      set_bins(20, -8, 4, 4, -12, 0, 0, 16);
      send_frame(4, -1, 0);
      @(negedge clk);
      check("missing_last_err", frame_err1, 1);
      @(posedge clk);
      #1;
      wait_idle();

      // Reset in the middle of EMIT, after x1 has been taken.
      out_ready = 1'b1;
      rand_bins();
      send_frame(4, 3, 0);
      for (int c = 0; c < 50; c++) begin
         if ((out_valid1 === 1'b1) && (out_idx1 == 2'd2)) break;
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_out_valid", out_valid1, 0);
      check("mid_rst_out_real",  out_real1,  0);
      check("mid_rst_out_imag",  out_imag1,  0);
      check("mid_rst_out_idx",   out_idx1,   0);
      check("mid_rst_out_last",  out_last1,  0);
      check("mid_rst_in_ready",  in_ready1,  0);
      @(negedge clk);
      check("mid_rst_in_ready_rise", in_ready1, 1);
      @(posedge clk);
      #1;
      or_mode = 1;
      rand_bins();
      send_frame(4, 3, 2);
      wait_idle();

      // Randomised frames, back to back, with occasional framing faults.
      for (int f = 0; f < 40; f++) begin
         int p;
         rand_bins();
         p = int'($urandom_range(0, 9));
         if (p == 0) begin
            n = int'($urandom_range(1, 3));
            send_frame(n, n - 1, 3);
         end else if (p == 1) begin
            send_frame(4, -1, 3);
         end else begin
            send_frame(4, 3, 3);
         end
      end
      wait_idle();
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
